// File: rtl/calc_radix_conv.sv
// Sequential BCD <-> binary radix converter with a start/busy/done handshake.
// Optional macro CALC_EARLY_EXIT_EN: unpack stops as soon as the quotient reaches zero.
module calc_radix_conv #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                mode,
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic [BIN_W-1:0]    bin_in,
    output logic                busy,
    output logic                done,
    output logic [BIN_W-1:0]    bin_out,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int DCW   = $clog2(DIGITS + 1);
    localparam int BCW   = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam logic [BIN_W-1:0] MAX_VAL   = BIN_W'(pow10(DIGITS) - 1);
    localparam logic [DCW-1:0]   DIG_END   = DCW'(DIGITS);
    localparam logic [BCW-1:0]   BIT_LAST  = BCW'(BIN_W - 1);
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

    // One restoring-division step: returns {next dividend/quotient, next remainder}.
    // The stored remainder is always below 10, so four bits hold it between steps.
    function automatic logic [BIN_W+3:0] div_step(input logic [BIN_W-1:0] a,
                                                  input logic [3:0] r);
        logic [4:0] r_sh;
        logic       q;
        logic [3:0] r_n;
        r_sh = {r, a[BIN_W-1]};
        q    = (r_sh >= 5'd10);
        r_n  = q ? 4'(r_sh - 5'd10) : r_sh[3:0];
        return {(a << 1) | BIN_W'(q), r_n};
    endfunction

    typedef enum logic [1:0] {ST_IDLE, ST_PACK, ST_DIV, ST_DONE} state_t;

    state_t             state;
    logic [BIN_W-1:0]   acc;
    logic [3:0]         rem;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   dig;
    logic [DCW-1:0]     dcnt;
    logic [BCW-1:0]     bcnt;
    logic               bad;
    logic               ovf;

    logic [3:0]         pack_digit;
    logic [BIN_W-1:0]   pack_acc;
    logic [BIN_W-1:0]   step_acc;
    logic [3:0]         step_rem;
    logic [BCD_W-1:0]   dig_next;

    always_comb begin
        pack_digit            = bcd_q[BCD_W-1 -: 4];
        pack_acc              = (acc << 3) + (acc << 1) + BIN_W'(pack_digit);
        {step_acc, step_rem}  = div_step(acc, rem);
        dig_next              = (dig >> 4) | (BCD_W'(step_rem) << (BCD_W - 4));
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            acc     <= '0;
            rem     <= '0;
            bcd_q   <= '0;
            dig     <= '0;
            dcnt    <= '0;
            bcnt    <= '0;
            bad     <= 1'b0;
            ovf     <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            bin_out <= '0;
            bcd_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bcd_q <= bcd_in;
                        acc   <= mode ? bin_in : '0;
                        rem   <= '0;
                        dig   <= '0;
                        dcnt  <= '0;
                        bcnt  <= '0;
                        bad   <= 1'b0;
                        ovf   <= mode && (bin_in > MAX_VAL);
                        state <= mode ? ST_DIV : ST_PACK;
                    end
                end
                // Most significant digit first; bad digits are remembered but not skipped.
                ST_PACK: begin
                    if (dcnt == DIG_END) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        err     <= bad;
                        bin_out <= bad ? '0 : acc;
                    end else begin
                        acc   <= pack_acc;
                        bad   <= bad | (pack_digit > 4'd9);
                        bcd_q <= bcd_q << 4;
                        dcnt  <= dcnt + 1'b1;
                    end
                end
                ST_DIV: begin
                    if (dcnt == DIG_END) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        err     <= ovf;
                        bcd_out <= ovf ? ALL_NINES : dig;
                    end else if (bcnt == BIT_LAST) begin
                        // Digit finished: quotient becomes the next dividend.
                        acc  <= step_acc;
                        rem  <= '0;
                        bcnt <= '0;
                        dig  <= dig_next;
                        dcnt <= dcnt + 1'b1;
`ifdef CALC_EARLY_EXIT_EN
                        if (step_acc == '0) begin
                            dig  <= dig_next >> (4 * (DIGITS - 1 - int'(dcnt)));
                            dcnt <= DIG_END;
                        end
`endif
                    end else begin
                        acc  <= step_acc;
                        rem  <= step_rem;
                        bcnt <= bcnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
